// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch-to-decode valid/ready handshake bundle
interface if_fetch_queue_if #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 32
);
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc_plus4;

    modport master (output out_valid, out_instr, out_pc_plus4, input out_ready);
    modport slave  (input out_valid, out_instr, out_pc_plus4, output out_ready);
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - PC owner with DEPTH-entry prefetch queue; IF_BYPASS_EN adds empty-queue bypass
module if_fetch_queue #(
    parameter int                   PC_WIDTH    = 10,
    parameter int                   INSTR_WIDTH = 32,
    parameter int                   DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         branch_taken,
    input  logic [PC_WIDTH-1:0]          branch_address,
    input  logic                         jump,
    input  logic [PC_WIDTH-1:0]          jump_address,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_data,
    if_fetch_queue_if.master             dec,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [PC_WIDTH-1:0]    target;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [PC_WIDTH-1:0]    pc4_q   [DEPTH];
    logic                   redirect;
    logic                   q_pop;
    logic                   push;
    logic                   write_en;
    logic                   bypass_take;

    assign pc_plus4  = pc + PC_WIDTH'(4);
    assign imem_addr = pc;
    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_address : branch_address;

    // q_pop is a pop of a stored entry; a bypassed pop never touches storage
    assign q_pop = (occupancy != '0) & dec.out_ready;
    assign push  = ~redirect & ((occupancy < OCC_W'(DEPTH)) | q_pop);

`ifdef IF_BYPASS_EN
    logic bypass_active;
    assign bypass_active    = (occupancy == '0) & reset_n;
    assign bypass_take      = bypass_active & ~redirect & dec.out_ready;
    assign dec.out_valid    = bypass_active ? ~redirect : (occupancy != '0);
    assign dec.out_instr    = bypass_active ? imem_data : instr_q[rd_ptr];
    assign dec.out_pc_plus4 = bypass_active ? pc_plus4  : pc4_q[rd_ptr];
`else
    assign bypass_take      = 1'b0;
    assign dec.out_valid    = (occupancy != '0);
    assign dec.out_instr    = instr_q[rd_ptr];
    assign dec.out_pc_plus4 = pc4_q[rd_ptr];
`endif

    assign write_en = push & ~bypass_take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (redirect) begin
            pc        <= target;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                pc <= pc_plus4;
            end
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (write_en && !q_pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!write_en && q_pop) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    // Storage is cleared so the head reads zero straight out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else if (write_en) begin
            instr_q[wr_ptr] <= imem_data;
            pc4_q[wr_ptr]   <= pc_plus4;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
    localparam logic [9:0] RPC = 10'h010;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc4;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_taken;
    logic [9:0]  branch_address;
    logic        jump;
    logic [9:0]  jump_address;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [2:0]  occupancy;

    int errors = 0;
    int checks = 0;

    ent_t       mq[$];
    logic [9:0] mpc;
    logic [9:0] delivered[$];

    if_fetch_queue_if #(.PC_WIDTH(10), .INSTR_WIDTH(32)) dec_if ();

    if_fetch_queue #(
        .PC_WIDTH(10), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(RPC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .jump           (jump),
        .jump_address   (jump_address),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .dec            (dec_if.master),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hA500_0000 ^ ({22'd0, a} * 32'h9E37_79B1);
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic model_reset();
        mq.delete();
        mpc = RPC;
    endtask

    // One clock: drive inputs, check against the queue model, advance the model at the edge
    task automatic cycle(input logic br, input logic [9:0] ba, input logic jp,
                         input logic [9:0] ja, input logic rdy);
        logic        redir;
        logic [9:0]  tgt;
        logic        ev;
        logic [31:0] ei;
        logic [9:0]  ep;
        logic        popped;
        logic        bypassed;
        logic        room;
        branch_taken   = br;
        branch_address = ba;
        jump           = jp;
        jump_address   = ja;
        dec_if.out_ready = rdy;
        #1;
        redir = br | jp;
        tgt   = jp ? ja : ba;
        if (mq.size() != 0) begin
            ev = 1'b1;
            ei = mq[0].instr;
            ep = mq[0].pc4;
        end else begin
            ev = BYP ? !redir : 1'b0;
            ei = mem_word(mpc);
            ep = mpc + 10'd4;
        end
        checks++;
        if (imem_addr !== mpc) begin
            errors++;
            $display("FAIL imem_addr: got %h expected %h", imem_addr, mpc);
        end
        checks++;
        if (occupancy !== 3'(mq.size())) begin
            errors++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, mq.size());
        end
        checks++;
        if (dec_if.out_valid !== ev) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", dec_if.out_valid, ev);
        end
        if (ev) begin
            checks++;
            if (dec_if.out_instr !== ei) begin
                errors++;
                $display("FAIL out_instr: got %h expected %h", dec_if.out_instr, ei);
            end
            checks++;
            if (dec_if.out_pc_plus4 !== ep) begin
                errors++;
                $display("FAIL out_pc_plus4: got %h expected %h", dec_if.out_pc_plus4, ep);
            end
        end
        popped = ev & rdy;
        if (popped) delivered.push_back(dec_if.out_pc_plus4);
        @(posedge clk);
        if (redir) begin
            mq.delete();
            mpc = tgt;
        end else begin
            room     = (mq.size() < 4) || popped;
            bypassed = popped && (mq.size() == 0);
            if (popped && !bypassed) void'(mq.pop_front());
            if (room) begin
                if (!bypassed) mq.push_back('{mem_word(mpc), mpc + 10'd4});
                mpc = mpc + 10'd4;
            end
        end
        @(negedge clk);
        branch_taken = 1'b0;
        jump         = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic check_delivered(input string name, input int idx, input logic [9:0] exp);
        checks++;
        if (delivered.size() <= idx) begin
            errors++;
            $display("FAIL %s: got %0d deliveries expected more than %0d", name, delivered.size(), idx);
        end else if (delivered[idx] !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, delivered[idx], exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
        reset_n = 1'b0;
        #1;
        checks++;
        if (imem_addr !== RPC) begin
            errors++;
            $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, RPC);
        end
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        checks++;
        if (dec_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", dec_if.out_valid);
        end
        checks++;
        if (dec_if.out_instr !== 32'd0 || dec_if.out_pc_plus4 !== 10'd0) begin
            errors++;
            $display("FAIL reset_out_data: got %h/%h expected 0/0", dec_if.out_instr, dec_if.out_pc_plus4);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        delivered.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
        check_delivered("reset_order0", 0, 10'h014);
        check_delivered("reset_order1", 1, 10'h018);
        check_delivered("reset_order2", 2, 10'h01C);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b0);
        #1;
        checks++;
        if (occupancy !== 3'd4) begin
            errors++;
            $display("FAIL bp_occupancy: got %0d expected 4", occupancy);
        end
        checks++;
        if (imem_addr !== RPC + 10'd16) begin
            errors++;
            $display("FAIL bp_pc_hold: got %h expected %h", imem_addr, RPC + 10'd16);
        end
        delivered.delete();
        for (int i = 0; i < 6; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
        check_delivered("bp_drain0", 0, 10'h014);
        check_delivered("bp_drain1", 1, 10'h018);
        check_delivered("bp_drain2", 2, 10'h01C);
        check_delivered("bp_drain3", 3, 10'h020);
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b0);
        cycle(1'b1, 10'h040, 1'b0, 10'h0, 1'b1);
        #1;
        checks++;
        if (occupancy !== 3'd0 || imem_addr !== 10'h040) begin
            errors++;
            $display("FAIL redirect_flush: got occ=%0d addr=%h expected occ=0 addr=040", occupancy, imem_addr);
        end
        delivered.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
        check_delivered("redirect_first", 0, 10'h044);
    endtask

    task automatic test_priority();
        cycle(1'b1, 10'h040, 1'b1, 10'h080, 1'b1);
        #1;
        checks++;
        if (imem_addr !== 10'h080) begin
            errors++;
            $display("FAIL jump_priority: got %h expected 080", imem_addr);
        end
        delivered.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
        check_delivered("jump_first", 0, 10'h084);
    endtask

    task automatic test_wrap();
        cycle(1'b1, 10'h3FC, 1'b0, 10'h0, 1'b0);
        cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b0);
        #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc_plus4 !== 10'h000) begin
            errors++;
            $display("FAIL wrap_pc_plus4: got v=%b %h expected v=1 000", dec_if.out_valid, dec_if.out_pc_plus4);
        end
        checks++;
        if (imem_addr !== 10'h000) begin
            errors++;
            $display("FAIL wrap_fetch_addr: got %h expected 000", imem_addr);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
    endtask

    task automatic test_bypass();
        do_reset();
        dec_if.out_ready = 1'b1;
        #1;
        checks++;
        if (dec_if.out_valid !== BYP) begin
            errors++;
            $display("FAIL bypass_valid_empty: got %b expected %b", dec_if.out_valid, BYP);
        end
        if (BYP) begin
            checks++;
            if (dec_if.out_instr !== mem_word(RPC)) begin
                errors++;
                $display("FAIL bypass_instr: got %h expected %h", dec_if.out_instr, mem_word(RPC));
            end
        end
        cycle(1'b0, 10'h0, 1'b0, 10'h0, 1'b1);
        #1;
        checks++;
        if (dec_if.out_valid !== 1'b1 || occupancy !== (BYP ? 3'd0 : 3'd1)) begin
            errors++;
            $display("FAIL bypass_steady: got v=%b occ=%0d expected v=1 occ=%0d",
                     dec_if.out_valid, occupancy, BYP ? 0 : 1);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            cycle(r == 0 || r == 2, 10'($urandom_range(0, 255) * 4),
                  r == 1 || r == 2, 10'($urandom_range(0, 255) * 4),
                  $urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        branch_taken     = 1'b0;
        branch_address   = '0;
        jump             = 1'b0;
        jump_address     = '0;
        dec_if.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_backpressure();
        test_redirect();
        test_priority();
        test_wrap();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage: owns the PC, addresses the combinational instruction memory and buffers fetched instructions in a DEPTH-entry queue with a valid/ready handshake to decode. Replaces the single-register enable-stall fetch with decoupled prefetch. Branch/jump redirects flush the queue. Sits between the instruction memory and the IF/ID boundary.

## Interface
- PC_WIDTH, 10, PC / address width in bits
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- branch_taken  input  1  redirect to branch_address
- branch_address  input  PC_WIDTH  branch target
- jump  input  1  redirect to jump_address (wins over branch_taken)
- jump_address  input  PC_WIDTH  jump target
- imem_addr  output  PC_WIDTH  instruction memory read address (= pc)
- imem_data  input  INSTR_WIDTH  combinational read data for imem_addr
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  INSTR_WIDTH  head instruction
- out_pc_plus4  output  PC_WIDTH  head's fetch PC + 4
- occupancy  output  $clog2(DEPTH+1)  entries held

## Operation
- redirect = jump | branch_taken; target = jump ? jump_address : branch_address.
- pop = out_valid & out_ready. push = ~redirect & (occupancy < DEPTH | pop).
- push: write {imem_data, pc+4} at write pointer; pc <= pc + 4.
- no push, no redirect: pc holds (full backpressure).
- redirect: queue flushed (occupancy <= 0, pointers reset), pc <= target, nothing pushed that cycle; any coincident pop is discarded with the flush.
- PC arithmetic modulo 2^PC_WIDTH: pc = 2^PC_WIDTH−4 → pc+4 = 0, no flag.
- occupancy update: +1 push only, −1 pop only, unchanged both/neither, 0 on redirect.
- Pointers wrap modulo DEPTH.
- Queue in order; out_instr/out_pc_plus4 from head entry.

## Timing
- Reset (reset_n low, async): pc = RESET_PC, occupancy = 0, pointers 0, out_valid = 0, imem_addr = RESET_PC; out_instr/out_pc_plus4 = 0.
- Without bypass: fetch at edge N → entry visible at out_* after edge N (1 cycle fetch-to-decode).
- Redirect at edge N: imem_addr = target after N; first target instruction pushed at N+1, out_valid at N+1 (bypass: after N, combinationally).
- Steady stream with out_ready = 1: one instruction per cycle, occupancy steady at 1 (0 with bypass).
- Full with out_ready = 0: pc, occupancy = DEPTH, out_* stable until pop.
- out_valid/out_* depend only on registered state (no bypass); occupancy always registered.
- Reset asserted mid-stream: queue contents dropped, fetch restarts at RESET_PC after release.

## Configuration
- IF_BYPASS_EN defined: when occupancy = 0 and reset_n high, out_valid = ~redirect, out_instr = imem_data, out_pc_plus4 = pc+4 combinationally; if popped, entry not written (pc still advances); if not popped, written normally. Zero-cycle fetch latency on empty queue.
- Undefined: no combinational path imem_data → out_*; out_valid = (occupancy ≠ 0).

## Test plan
- Reset: reset_n low mid-run with RESET_PC=0x10 → imem_addr=0x10, occupancy=0, out_valid=0 immediately; after release instructions at 0x10,0x14,0x18 in order, out_pc_plus4=0x14,0x18,0x1C.
- Backpressure: out_ready=0 for 8 cycles, DEPTH=4 → occupancy saturates at 4, pc held at RESET_PC+16; release → 4 queued entries drain in order, no loss/duplication.
- Redirect flush: occupancy=3, branch_taken=1 with branch_address=0x40 and out_ready=1 → next cycle occupancy=0, imem_addr=0x40, next delivered instruction from 0x40 with out_pc_plus4=0x44.
- Priority: jump=1 (0x80) with branch_taken=1 (0x40) same cycle → fetch resumes at 0x80.
- Wrap: PC_WIDTH=10, pc reaches 0x3FC → pushed out_pc_plus4=0x000, next fetch address 0x000.
- Bypass (IF_BYPASS_EN): empty queue, out_ready=1 → out_valid=1 and out_instr=imem_data same cycle, occupancy remains 0; without macro first valid one cycle later.
